// File: rtl/irq_request_unit_p.sv
// irq_request_unit_p: parametrised interrupt request register for the PIC datapath.
// Synchronises raw request lines, latches them per channel in edge or level mode,
// masks them, resolves the highest-priority pending channel from a rotatable base,
// clears requests through an ack handshake and offers a registered IRR/pending read.
module irq_request_unit_p #(
  parameter int unsigned N_IRQ       = 8,
  parameter int unsigned IDX_W       = $clog2(N_IRQ),
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] level_mode,
  input  logic [N_IRQ-1:0] mask,
  input  logic             init,
  input  logic [IDX_W-1:0] prio_base,
  input  logic             ack_valid,
  input  logic [IDX_W-1:0] ack_index,
  output logic             ack_done,
  output logic             ack_err,
  input  logic             rd_en,
  input  logic             rd_sel,
  output logic [N_IRQ-1:0] rd_data,
  output logic             rd_valid,
  output logic             int_req,
  output logic             highest_valid,
  output logic [IDX_W-1:0] highest_index
);

  logic [SYNC_STAGES-1:0][N_IRQ-1:0] syncChain;
  logic [N_IRQ-1:0] syncLine;
  logic [N_IRQ-1:0] prevLine;
  logic [N_IRQ-1:0] riseVec;
  logic [N_IRQ-1:0] irr;
  logic [N_IRQ-1:0] irrNext;
  logic [N_IRQ-1:0] pendingVec;
  logic [N_IRQ-1:0] ackVec;
  logic             ackInRange;
  logic             ackTargetSet;
  logic             ackErrNext;
  logic [IDX_W-1:0] baseIdx;
  logic [IDX_W-1:0] winIdx;
  logic             winFound;
  int unsigned      scanPos;

  assign syncLine   = syncChain[SYNC_STAGES-1];
  assign riseVec    = syncLine & ~prevLine;
  assign pendingVec = irr & ~mask;

  // Synchroniser chain and one-cycle edge history (init also lands here as prev <= sync)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncChain <= '0;
      prevLine  <= '0;
    end else begin
      syncChain <= {syncChain[SYNC_STAGES-2:0], irq_in};
      prevLine  <= syncLine;
    end
  end

  // Ack decode: one-hot clear vector and error flag for out-of-range or already-clear targets
  always_comb begin
    ackVec       = '0;
    ackTargetSet = 1'b0;
    ackInRange   = (32'(ack_index) < N_IRQ);
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (32'(ack_index) == i) begin
        ackVec[i]    = ack_valid && ackInRange;
        ackTargetSet = irr[i];
      end
    end
    ackErrNext = !ackInRange || !ackTargetSet;
  end

  // Next IRR: init clears all; level follows the line unless acked; edge sets on rise, set beats ack
  always_comb begin
    irrNext = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (init) begin
        irrNext[i] = 1'b0;
      end else if (level_mode[i]) begin
        irrNext[i] = syncLine[i] & ~ackVec[i];
      end else begin
        irrNext[i] = riseVec[i] | (irr[i] & ~ackVec[i]);
      end
    end
  end

  // Rotating priority scan: first pending channel from base upwards, wrapping modulo N_IRQ
  always_comb begin
    winIdx   = '0;
    winFound = 1'b0;
    scanPos  = 0;
    baseIdx  = (32'(prio_base) < N_IRQ) ? prio_base : '0;
    for (int unsigned k = 0; k < N_IRQ; k++) begin
      scanPos = 32'(baseIdx) + k;
      if (scanPos >= N_IRQ) begin
        scanPos = scanPos - N_IRQ;
      end
      if (!winFound && pendingVec[IDX_W'(scanPos)]) begin
        winFound = 1'b1;
        winIdx   = IDX_W'(scanPos);
      end
    end
  end

  // Request register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irr <= '0;
    end else begin
      irr <= irrNext;
    end
  end

  // Registered interrupt, priority, ack and read-port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_req       <= 1'b0;
      highest_valid <= 1'b0;
      highest_index <= '0;
      ack_done      <= 1'b0;
      ack_err       <= 1'b0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
    end else begin
      int_req       <= |pendingVec;
      highest_valid <= winFound;
      highest_index <= winIdx;
      ack_done      <= ack_valid;
      ack_err       <= ack_valid && ackErrNext;
      rd_valid      <= rd_en;
      if (rd_en) begin
        rd_data <= rd_sel ? pendingVec : irr;
      end
    end
  end

endmodule

// File: tb/tb_irq_request_unit_p.sv
// Directed bench for irq_request_unit_p: 8-channel instance plus a 6-channel instance
// for out-of-range ack index and out-of-range priority base.
module tb_irq_request_unit_p;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in, level_mode, mask;
  logic       init;
  logic [2:0] prio_base;
  logic       ack_valid;
  logic [2:0] ack_index;
  logic       ack_done, ack_err;
  logic       rd_en, rd_sel;
  logic [7:0] rd_data;
  logic       rd_valid, int_req, highest_valid;
  logic [2:0] highest_index;

  logic [5:0] irq6, lvl6, mask6, rd6;
  logic [2:0] prio6, ack6i, hi6;
  logic       ack6v, ack6d, ack6e, rdv6, ireq6, hv6;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  irq_request_unit_p #(.N_IRQ(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .level_mode(level_mode), .mask(mask),
    .init(init), .prio_base(prio_base), .ack_valid(ack_valid), .ack_index(ack_index),
    .ack_done(ack_done), .ack_err(ack_err), .rd_en(rd_en), .rd_sel(rd_sel),
    .rd_data(rd_data), .rd_valid(rd_valid), .int_req(int_req),
    .highest_valid(highest_valid), .highest_index(highest_index)
  );

  irq_request_unit_p #(.N_IRQ(6), .SYNC_STAGES(2)) dut6 (
    .clk(clk), .rst_n(rst_n), .irq_in(irq6), .level_mode(lvl6), .mask(mask6),
    .init(1'b0), .prio_base(prio6), .ack_valid(ack6v), .ack_index(ack6i),
    .ack_done(ack6d), .ack_err(ack6e), .rd_en(1'b0), .rd_sel(1'b0),
    .rd_data(rd6), .rd_valid(rdv6), .int_req(ireq6),
    .highest_valid(hv6), .highest_index(hi6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b1; irq_in = '0; level_mode = '0; mask = '0; init = 1'b0; prio_base = '0;
    ack_valid = 1'b0; ack_index = '0; rd_en = 1'b0; rd_sel = 1'b0;
    irq6 = '0; lvl6 = '0; mask6 = '0; prio6 = '0; ack6v = 1'b0; ack6i = '0;
    #2 rst_n = 1'b0;

    // 1. reset / idle
    tick();
    chk("rst_int_req", 32'(int_req), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_hv", 32'(highest_valid), 0);
    chk("rst_ack_done", 32'(ack_done), 0);
    rst_n = 1'b1;
    tick();
    rd_en = 1'b1; rd_sel = 1'b0;
    tick();
    chk("idle_rd_valid", 32'(rd_valid), 1);
    chk("idle_rd_data", 32'(rd_data), 0);
    rd_en = 1'b0;
    tick();
    chk("idle_rd_valid_pulse", 32'(rd_valid), 0);
    rd_en = 1'b1;

    // 2. edge latch on channel 5, then ack
    irq_in = 8'h20;
    tick(); tick(); tick();
    chk("edge_int_req_E3", 32'(int_req), 0);
    irq_in = 8'h00;
    tick();
    chk("edge_int_req_E4", 32'(int_req), 1);
    chk("edge_hv_E4", 32'(highest_valid), 1);
    chk("edge_hi_E4", 32'(highest_index), 5);
    chk("edge_irr_E3", 32'(rd_data), 32'h20);
    tick(); tick();
    chk("edge_hold_after_fall", 32'(rd_data), 32'h20);
    ack_valid = 1'b1; ack_index = 3'd5;
    tick();
    chk("ack5_done", 32'(ack_done), 1);
    chk("ack5_err", 32'(ack_err), 0);
    chk("ack5_int_req_still", 32'(int_req), 1);
    ack_valid = 1'b0;
    tick();
    chk("ack5_int_req_clear", 32'(int_req), 0);
    chk("ack5_done_pulse", 32'(ack_done), 0);
    chk("ack5_irr_clear", 32'(rd_data), 0);

    // 3. level channel 2 with ack, edge channel 3 rise+ack collision
    level_mode = 8'h04; irq_in = 8'h04;
    tick(); tick(); tick(); tick();
    chk("lvl_irr", 32'(rd_data), 32'h04);
    chk("lvl_hi", 32'(highest_index), 2);
    ack_valid = 1'b1; ack_index = 3'd2;
    tick();
    chk("lvl_ack_done", 32'(ack_done), 1);
    chk("lvl_ack_err", 32'(ack_err), 0);
    ack_valid = 1'b0;
    tick();
    chk("lvl_irr_dropped", 32'(rd_data), 0);
    chk("lvl_int_req_dropped", 32'(int_req), 0);
    tick();
    chk("lvl_irr_relatched", 32'(rd_data), 32'h04);
    chk("lvl_int_req_back", 32'(int_req), 1);
    irq_in = 8'h0C;
    tick(); tick(); tick(); tick();
    chk("ch3_latched", 32'(rd_data), 32'h0C);
    irq_in = 8'h04;
    tick(); tick(); tick();
    irq_in = 8'h0C;
    tick(); tick();
    ack_valid = 1'b1; ack_index = 3'd3;
    tick();
    chk("collide_done", 32'(ack_done), 1);
    chk("collide_err", 32'(ack_err), 0);
    ack_valid = 1'b0;
    tick();
    chk("collide_set_wins", 32'(rd_data), 32'h0C);
    irq_in = 8'h00;
    tick(); tick(); tick();
    init = 1'b1;
    tick();
    init = 1'b0; level_mode = 8'h00;
    tick();
    chk("cleanup_irr", 32'(rd_data), 0);

    // 4. mask and rotating priority
    mask = 8'h10; prio_base = 3'd5; irq_in = 8'h92;
    tick(); tick(); tick(); tick();
    chk("rot_irr", 32'(rd_data), 32'h92);
    chk("rot_int_req", 32'(int_req), 1);
    chk("rot_hi_base5", 32'(highest_index), 7);
    prio_base = 3'd0;
    tick();
    chk("rot_hi_base0", 32'(highest_index), 1);
    rd_sel = 1'b1;
    tick();
    chk("rd_pending", 32'(rd_data), 32'h82);
    rd_sel = 1'b0;
    tick();
    chk("rd_irr", 32'(rd_data), 32'h92);
    mask = 8'h00; prio_base = 3'd2;
    tick();
    chk("unmask_hi_base2", 32'(highest_index), 4);
    mask = 8'hFF;
    tick();
    chk("allmask_int_req", 32'(int_req), 0);
    chk("allmask_hv", 32'(highest_valid), 0);
    chk("allmask_hi", 32'(highest_index), 0);
    mask = 8'h00; prio_base = 3'd0;

    // 5. init with a line held high
    irq_in = 8'h93;
    tick(); tick(); tick(); tick();
    chk("init_pre_irr", 32'(rd_data), 32'h93);
    init = 1'b1;
    tick();
    init = 1'b0;
    tick();
    chk("init_irr_clear", 32'(rd_data), 0);
    chk("init_int_req", 32'(int_req), 0);
    tick();
    chk("init_no_relatch", 32'(rd_data), 0);
    chk("init_no_relatch_int", 32'(int_req), 0);
    level_mode = 8'h01;
    tick(); tick();
    chk("init_lvl_relatch", 32'(rd_data), 32'h01);
    chk("init_lvl_int_req", 32'(int_req), 1);
    chk("init_lvl_hi", 32'(highest_index), 0);

    // 6. bad acks, out-of-range base, async reset mid-latency
    ack_valid = 1'b1; ack_index = 3'd3;
    irq6 = 6'h11; prio6 = 3'd7; ack6v = 1'b1; ack6i = 3'd7;
    tick();
    chk("badack_done", 32'(ack_done), 1);
    chk("badack_err", 32'(ack_err), 1);
    chk("n6_ack_done", 32'(ack6d), 1);
    chk("n6_ack_err_range", 32'(ack6e), 1);
    ack_valid = 1'b0; ack6v = 1'b0;
    tick();
    chk("badack_no_change", 32'(rd_data), 32'h01);
    chk("badack_err_pulse", 32'(ack_err), 0);
    tick(); tick();
    chk("n6_hv", 32'(hv6), 1);
    chk("n6_base_oor_hi", 32'(hi6), 0);
    prio6 = 3'd4;
    tick();
    chk("n6_base4_hi", 32'(hi6), 4);
    prio6 = 3'd5;
    tick();
    chk("n6_base5_wrap_hi", 32'(hi6), 0);
    irq_in = 8'hD3;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_int_req", 32'(int_req), 0);
    chk("arst_rd_data", 32'(rd_data), 0);
    chk("arst_hv", 32'(highest_valid), 0);
    chk("arst_rd_valid", 32'(rd_valid), 0);
    chk("arst_n6_hv", 32'(hv6), 0);
    irq_in = 8'h00; level_mode = 8'h00; irq6 = '0;
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    chk("arst_lost_int_req", 32'(int_req), 0);
    chk("arst_lost_irr", 32'(rd_data), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
